// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum trailer is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERR
    } ldr_state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = stream source / memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [31:0]       wd;

    modport master (
        input  in_valid, in_data,
        output in_ready, we, wa, wd
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, we, wa, wd
    );
endinterface

// File: rtl/imem_byte_packer.sv
// Little-endian 4-byte packer: first pushed byte ends up in word_out[7:0].
// full flags the push that completes a word, so the FSM can write on the very next cycle.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        full
);

    logic [31:0] word_q;
    logic [1:0]  cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (clr) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (push) begin
            word_q <= {byte_in, word_q[31:8]};
            cnt_q  <= cnt_q + 2'd1;
        end
    end

    assign word_out = word_q;
    assign full     = push && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Packs a length-prefixed byte stream into 32-bit words and writes them to instruction memory
// while holding the core in reset. Define IMEM_LOADER_CHECKSUM_EN for an XOR checksum trailer byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    imem_loader_if.master     bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [8:0] MAX_N = 9'(MAX_WORDS);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam ldr_state_t END_STATE = CHECK;
`else
    localparam ldr_state_t END_STATE = DONE;
`endif

    ldr_state_t      state_q, state_d;
    logic [7:0]      n_q, n_d;
    logic [ADDR_W:0] words_q, words_d;
    logic            accept, pack_clr, pack_full;
    logic [31:0]     pack_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      xor_q, xor_d;
`endif

    assign accept = bus.in_valid && bus.in_ready;

    imem_byte_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clr      (pack_clr),
        .push     (accept && (state_q == DATA)),
        .byte_in  (bus.in_data),
        .word_out (pack_word),
        .full     (pack_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            words_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            words_q <= words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        words_d      = words_q;
        pack_clr     = 1'b0;
        bus.in_ready = 1'b0;
        bus.we       = 1'b0;
        cpu_hold     = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d        = xor_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                done  = (state_q == DONE);
                error = (state_q == ERR);
                if (start) begin
                    state_d  = COUNT;
                    words_d  = '0;
                    pack_clr = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d    = '0;
`endif
                end
            end
            COUNT: begin
                bus.in_ready = 1'b1;
                cpu_hold     = 1'b1;
                if (accept) begin
                    n_d = bus.in_data;
                    if (bus.in_data == 8'd0)               state_d = END_STATE;
                    else if ({1'b0, bus.in_data} > MAX_N)  state_d = ERR;
                    else                                   state_d = DATA;
                end
            end
            DATA: begin
                bus.in_ready = 1'b1;
                cpu_hold     = 1'b1;
                if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ bus.in_data;
`endif
                    if (pack_full) state_d = WRITE;
                end
            end
            WRITE: begin
                bus.we   = 1'b1;
                cpu_hold = 1'b1;
                pack_clr = 1'b1;
                words_d  = words_q + 1'b1;
                // N was bounded by MAX_WORDS in COUNT, so the index never wraps
                if (32'(words_q) + 32'd1 == 32'(n_q)) state_d = END_STATE;
                else                                  state_d = DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                bus.in_ready = 1'b1;
                cpu_hold     = 1'b1;
                if (accept) state_d = (bus.in_data == xor_q) ? DONE : ERR;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign bus.wa       = words_q[ADDR_W-1:0];
    assign bus.wd       = pack_word;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by stimulus, popped by a write monitor.
module tb_imem_loader;

    localparam int ADDR_W = 6;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            cpu_hold, done, error;
    logic [ADDR_W:0] words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] wa;
        logic [31:0]       wd;
    } wr_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    wr_t        exp_q[$];
    wr_t        mon_e;
    logic       prev_we = 1'b0;
    logic [7:0] cks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic exp_push(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        wr_t e;
        e.wa = a;
        e.wd = d;
        exp_q.push_back(e);
    endtask

    // Write monitor: each we pulse must match the oldest expected write
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            $display("WRITE wa=%0d wd=%h hold=%b", bus.wa, bus.wd, cpu_hold);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_we: got wa=%0d wd=%h, expected no write", bus.wa, bus.wd);
            end else begin
                mon_e = exp_q.pop_front();
                check("wa", 32'(bus.wa), 32'(mon_e.wa));
                check("wd", bus.wd, mon_e.wd);
                check("hold_at_we", 32'(cpu_hold), 32'd1);
                check("we_single_cycle", 32'(prev_we), 32'd0);
            end
        end
        prev_we = bus.we;
    end

    task automatic send_byte(input logic [7:0] b, input int gap, input bit hold_chk);
        int t;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: byte %h not accepted, expected in_ready within 50 cycles", b);
        end
        if (hold_chk) check("hold_busy", 32'(cpu_hold), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], int'($urandom_range(0, gap_max)), 1'b1);
            cks ^= w[8*i +: 8];
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic begin_load(input logic [7:0] n);
        $display("LOAD n=%0d", n);
        pulse_start();
        cks = 8'h00;
        send_byte(n, 0, 1'b1);
    endtask

    task automatic send_trailer();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(cks, 0, 1'b1);
`endif
    endtask

    task automatic wait_end(input string name);
        int t;
        t = 0;
        while (!(done || error) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: done/error not seen, expected within 100 cycles", name);
        end
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_we", 32'(bus.we), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b1;

        // Two words, back-to-back bytes
        begin_load(8'd2);
        exp_push(6'd0, 32'h12345678);
        exp_push(6'd1, 32'hDEADBEEF);
        send_word(32'h12345678, 0);
        send_word(32'hDEADBEEF, 0);
        send_trailer();
        wait_end("t1");
        check("t1_done", 32'(done), 32'd1);
        check("t1_error", 32'(error), 32'd0);
        check("t1_words", 32'(words_loaded), 32'd2);
        check("t1_hold", 32'(cpu_hold), 32'd0);

        // Same stream with random valid gaps
        begin_load(8'd2);
        exp_push(6'd0, 32'h12345678);
        exp_push(6'd1, 32'hDEADBEEF);
        send_word(32'h12345678, 3);
        send_word(32'hDEADBEEF, 3);
        send_trailer();
        wait_end("t2");
        check("t2_done", 32'(done), 32'd1);
        check("t2_words", 32'(words_loaded), 32'd2);

        // Oversized count aborts immediately
        begin_load(8'd65);
        wait_end("t3");
        check("t3_error", 32'(error), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        check("t3_hold", 32'(cpu_hold), 32'd0);
        check("t3_words", 32'(words_loaded), 32'd0);

        // Reset mid-load, then a clean one-word load
        begin_load(8'd1);
        send_byte(8'h01, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        reset = 1'b0;
        #1;
        check("t4_rst_hold", 32'(cpu_hold), 32'd0);
        check("t4_rst_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        begin_load(8'd1);
        exp_push(6'd0, 32'hE3000001);
        send_word(32'hE3000001, 0);
        send_trailer();
        wait_end("t4");
        check("t4_done", 32'(done), 32'd1);
        check("t4_words", 32'(words_loaded), 32'd1);

        // start during a load is ignored
        begin_load(8'd1);
        exp_push(6'd0, 32'h44332211);
        send_byte(8'h11, 0, 1'b1);
        send_byte(8'h22, 0, 1'b1);
        cks = 8'h33;
        pulse_start();
        send_byte(8'h33, 0, 1'b1);
        send_byte(8'h44, 0, 1'b1);
        cks ^= 8'h77;
        send_trailer();
        wait_end("t6");
        check("t6_done", 32'(done), 32'd1);
        check("t6_words", 32'(words_loaded), 32'd1);

        // Zero-length program
        begin_load(8'd0);
        send_trailer();
        wait_end("t0");
        check("t0_done", 32'(done), 32'd1);
        check("t0_words", 32'(words_loaded), 32'd0);

        // Largest accepted program: word i = {i,i,i,i}
        begin_load(8'd64);
        for (int i = 0; i < 64; i++) begin
            exp_push(6'(i), {4{8'(i)}});
            send_word({4{8'(i)}}, 0);
        end
        send_trailer();
        wait_end("tmax");
        check("tmax_done", 32'(done), 32'd1);
        check("tmax_words", 32'(words_loaded), 32'd64);

`ifdef IMEM_LOADER_CHECKSUM_EN
        begin_load(8'd1);
        exp_push(6'd0, 32'hFF0055AA);
        send_word(32'hFF0055AA, 0);
        send_byte(8'h00, 0, 1'b1);
        wait_end("t5a");
        check("t5a_done", 32'(done), 32'd1);
        check("t5a_error", 32'(error), 32'd0);
        begin_load(8'd1);
        exp_push(6'd0, 32'hFF0055AA);
        send_word(32'hFF0055AA, 0);
        send_byte(8'h01, 0, 1'b1);
        wait_end("t5b");
        check("t5b_error", 32'(error), 32'd1);
        check("t5b_done", 32'(done), 32'd0);
        check("t5b_words", 32'(words_loaded), 32'd1);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
